// File: rtl/mem_access_unit.sv
// Load/store unit bridging a pipeline request port to a single-word memory port.
// Handles alignment checking, byte-lane steering, load extension and an ack timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        busy_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic        misaligned;
  logic        isStore;
  logic [3:0]  beSel;
  logic [31:0] wdataFmt;
  logic [15:0] halfSel;
  logic [7:0]  byteSel;
  logic [31:0] loadData;

  // Request decode: alignment check and store-lane replication on the incoming request
  always_comb begin
    misaligned = 1'b0;
    wdataFmt   = wdata_i;
    case (op_i)
      OP_LW, OP_SW:         misaligned = (addr_i[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr_i[0];
      default:              misaligned = 1'b0;
    endcase
    case (op_i)
      OP_SH:   wdataFmt = {wdata_i[15:0], wdata_i[15:0]};
      OP_SB:   wdataFmt = {4{wdata_i[7:0]}};
      default: wdataFmt = wdata_i;
    endcase
  end

  // Byte-enable generation and load extraction from the latched request
  always_comb begin
    isStore = op_q[2] & (op_q[1] | op_q[0]);
    beSel   = 4'b1111;
    case (op_q)
      OP_LH, OP_LHU, OP_SH: beSel = addr_q[1] ? 4'b1100 : 4'b0011;
      OP_LB, OP_LBU, OP_SB: beSel = 4'b0001 << addr_q[1:0];
      default:              beSel = 4'b1111;
    endcase
    halfSel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (addr_q[1:0])
      2'b00:   byteSel = mem_rdata_i[7:0];
      2'b01:   byteSel = mem_rdata_i[15:8];
      2'b10:   byteSel = mem_rdata_i[23:16];
      default: byteSel = mem_rdata_i[31:24];
    endcase
    case (op_q)
      OP_LW:   loadData = mem_rdata_i;
      OP_LH:   loadData = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  loadData = {16'h0000, halfSel};
      OP_LB:   loadData = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  loadData = {24'h000000, byteSel};
      default: loadData = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d        = op_i;
          addr_d      = addr_i;
          mem_wdata_d = wdataFmt;
          if (misaligned) begin
            state_d     = RESP;
            rsp_err_d   = ERR_MISALIGN;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d = ACCESS;
            cnt_d   = 10'd0;
          end
        end
      end
      ACCESS: begin
        mem_en_o = 1'b1;
        mem_we_o = isStore;
        mem_be_o = beSel;
        // An ack arriving on the expiry cycle still wins over the timeout
        if (mem_ack_i) begin
          state_d     = RESP;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = loadData;
        end else if (cnt_q + 10'd1 == TimeoutCnt) begin
          state_d     = RESP;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = ~req_ready_o;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      addr_q      <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      cnt_q       <= 10'd0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit, built with TIMEOUT=4.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int failCount  = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .op_i        (op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one request and returns 1ns after the accepting edge
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic runAccess(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] rd, input logic [31:0] expRd,
                           input logic expWe, input logic [3:0] expBe, input logic [31:0] expWd,
                           input logic chkBe, input logic chkWd);
    applyStimulus(o, a, w);
    checkOutput({tag, "_en"}, 32'(mem_en), 32'd1);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'(expWe));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    if (chkBe) checkOutput({tag, "_be"}, 32'(mem_be), 32'(expBe));
    if (chkWd) checkOutput({tag, "_wdata"}, mem_wdata, expWd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_rdata"}, rsp_rdata, expRd);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_en_resp"}, 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_rspv_end"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_ready_end"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rdata_hold"}, rsp_rdata, expRd);
  endtask

  task automatic runMisaligned(input string tag, input logic [2:0] o, input logic [31:0] a);
    applyStimulus(o, a, 32'hFFFF_FFFF);
    checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'd1);
    checkOutput({tag, "_en"}, 32'(mem_en), 32'd0);
    checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_rspv_end"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_en_end"}, 32'(mem_en), 32'd0);
    checkOutput({tag, "_err_hold"}, 32'(rsp_err), 32'd1);
  endtask

  initial begin
    int enCount;
    int rspCount;
    logic [1:0]  lastErr;
    logic [31:0] lastRd;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    op        = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    #2;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_en", 32'(mem_en), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_be", 32'(mem_be), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    runAccess("sb13", 3'b111, 32'h13, 32'hA5, 32'h0, 32'h0, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b1);
    runAccess("lh22", 3'b001, 32'h22, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    runAccess("lhu22", 3'b010, 32'h22, 32'h0, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    runAccess("sh02", 3'b110, 32'h2, 32'h1234_BEEF, 32'h0, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b1);
    runAccess("lw08", 3'b000, 32'h8, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0, 1'b1, 1'b0);
    runAccess("lb02", 3'b011, 32'h2, 32'h0, 32'h0080_0000, 32'hFFFF_FF80, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    runAccess("sw04", 3'b101, 32'h4, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'b1111, 32'h1234_5678, 1'b1, 1'b1);

    runMisaligned("lw06", 3'b000, 32'h6);
    runMisaligned("sh03", 3'b110, 32'h3);

    // Ack never arrives: count enable cycles and responses over a bounded window
    applyStimulus(3'b000, 32'h40, 32'h0);
    enCount  = 0;
    rspCount = 0;
    lastErr  = 2'b00;
    lastRd   = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      if (mem_en) enCount++;
      if (rsp_valid) begin
        rspCount++;
        lastErr = rsp_err;
        lastRd  = rsp_rdata;
      end
      @(posedge clk); #1;
    end
    checkOutput("to_en_cycles", 32'(enCount), 32'd4);
    checkOutput("to_rsp_count", 32'(rspCount), 32'd1);
    checkOutput("to_err", 32'(lastErr), 32'd2);
    checkOutput("to_rdata", lastRd, 32'd0);

    // Reset dropped in the middle of a store access
    applyStimulus(3'b101, 32'h8, 32'h1234_5678);
    checkOutput("rmid_en_before", 32'(mem_en), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_en", 32'(mem_en), 32'd0);
    checkOutput("rmid_ready", 32'(req_ready), 32'd1);
    checkOutput("rmid_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("rmid_addr", mem_addr, 32'd0);
    checkOutput("rmid_wdata", mem_wdata, 32'd0);
    checkOutput("rmid_err", 32'(rsp_err), 32'd0);
    rspCount = 0;
    @(posedge clk); #1;
    if (rsp_valid) rspCount++;
    @(posedge clk); #1;
    if (rsp_valid) rspCount++;
    rst_n = 1'b1;
    checkOutput("rmid_no_rsp", 32'(rspCount), 32'd0);
    runAccess("lbu01", 3'b100, 32'h1, 32'h0, 32'h0000_F000, 32'h0000_00F0, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0);

    // Spurious ack in IDLE, then req_valid held through ACCESS and RESP
    rspCount = 0;
    mem_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) rspCount++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    checkOutput("spur_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    op        = 3'b000;
    addr      = 32'h4;
    wdata     = 32'h0;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if (rsp_valid) rspCount++;
    checkOutput("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rspCount++;
      @(posedge clk); #1;
    end
    checkOutput("hold_rsp_count", 32'(rspCount), 32'd1);
    checkOutput("hold_idle_en", 32'(mem_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
